mem_port_arbiter: RTL and testbench

Shares one single-ported, fixed-latency memory between the CPU's instruction-fetch port and its data (MEM-stage) port so the core can run against a unified instruction/data RAM. Per-cycle arbitration gives the data port priority, with a starvation guard for fetch. Issued-request ownership is tracked through the memory latency, and each read response is routed back to the port that issued it. The block sits between `riscv_cpu`'s `instr_*`/`data_*` ports and the memory macro.

---
 rtl/riscv_mem_pkg.sv | 19 +
 rtl/mem_tag_pipe.sv | 32 +++
 rtl/mem_port_arbiter.sv | 85 ++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory port.
// Owner tags record which port issued each in-flight memory access.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DRD  = 2'd2
    } mem_owner_e;

    localparam int unsigned MEM_LAT_DEFAULT = 1;
    localparam int unsigned STARVE_W        = 4;

    // A flushed fetch keeps its slot in the pipe but loses its response.
    function automatic mem_owner_e drop_fetch(input mem_owner_e tag);
        return (tag == OWN_IF) ? OWN_NONE : tag;
    endfunction

endpackage

// File: rtl/mem_tag_pipe.sv
// Fixed-depth shift register of owner tags tracking accesses through the memory latency.
// Flush rewrites every fetch tag, including the one being pushed, to OWN_NONE.
module mem_tag_pipe
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       flush,
    input  mem_owner_e push_tag,
    output mem_owner_e out_tag
);

    mem_owner_e stage [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= OWN_NONE;
            end
        end else begin
            stage[0] <= flush ? drop_fetch(push_tag) : push_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= flush ? drop_fetch(stage[i-1]) : stage[i-1];
            end
        end
    end

    assign out_tag = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one fixed-latency memory, data first with a
// starvation guard for fetch, and routes each read response back to its issuer.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned MEM_LAT    = MEM_LAT_DEFAULT,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic [31:0] d_addr_i,
    input  logic [3:0]  d_we_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    logic [STARVE_W-1:0] starve_cnt;
    logic                fetch_first;
    mem_owner_e          push_tag;
    mem_owner_e          out_tag;

    always_comb begin
        fetch_first = (starve_cnt == STARVE_W'(STARVE_MAX));
        if_gnt_o    = !rst && if_req_i && (!d_req_i || fetch_first);
        d_gnt_o     = !rst && d_req_i && !(if_req_i && fetch_first);
        mem_req_o   = if_gnt_o | d_gnt_o;
        mem_addr_o  = if_gnt_o ? if_addr_i : d_addr_i;
        mem_we_o    = d_gnt_o ? d_we_i : '0;
        mem_wdata_o = d_wdata_i;
    end

    always_comb begin
        push_tag = OWN_NONE;
        if (if_gnt_o) begin
            push_tag = OWN_IF;
        end else if (d_gnt_o && (d_we_i == '0)) begin
            push_tag = OWN_DRD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (if_req_i && !if_gnt_o) begin
            if (starve_cnt != '1) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    mem_tag_pipe #(
        .DEPTH(MEM_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .clr      (rst),
        .flush    (if_flush_i),
        .push_tag (push_tag),
        .out_tag  (out_tag)
    );

    // Flush also kills a fetch response emerging in the same cycle.
    always_comb begin
        if_rvalid_o = !rst && (out_tag == OWN_IF) && !if_flush_i;
        d_rvalid_o  = !rst && (out_tag == OWN_DRD);
        if_rdata_o  = mem_rdata_i;
        d_rdata_o   = mem_rdata_i;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (latency 1, 2, 3) share stimulus and are
// compared each cycle against a queue-based model of grants and expected responses.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_flush = 1'b0;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic [3:0]  d_we = '0;
    logic [31:0] d_wdata = '0;

    logic        if_gnt [3];
    logic        if_rvalid [3];
    logic [31:0] if_rdata [3];
    logic        d_gnt [3];
    logic        d_rvalid [3];
    logic [31:0] d_rdata [3];
    logic        mreq [3];
    logic [31:0] maddr [3];
    logic [3:0]  mwe [3];
    logic [31:0] mwdata [3];
    logic [31:0] mrdata [3];
    logic [31:0] hist [3];

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_lat1 (
        .clk(clk), .rst(rst), .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_gnt_o(if_gnt[0]), .if_rvalid_o(if_rvalid[0]), .if_rdata_o(if_rdata[0]),
        .d_req_i(d_req), .d_addr_i(d_addr), .d_we_i(d_we), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt[0]), .d_rvalid_o(d_rvalid[0]), .d_rdata_o(d_rdata[0]),
        .mem_req_o(mreq[0]), .mem_addr_o(maddr[0]), .mem_we_o(mwe[0]),
        .mem_wdata_o(mwdata[0]), .mem_rdata_i(mrdata[0]));

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(STARVE_MAX)) u_lat2 (
        .clk(clk), .rst(rst), .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_gnt_o(if_gnt[1]), .if_rvalid_o(if_rvalid[1]), .if_rdata_o(if_rdata[1]),
        .d_req_i(d_req), .d_addr_i(d_addr), .d_we_i(d_we), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt[1]), .d_rvalid_o(d_rvalid[1]), .d_rdata_o(d_rdata[1]),
        .mem_req_o(mreq[1]), .mem_addr_o(maddr[1]), .mem_we_o(mwe[1]),
        .mem_wdata_o(mwdata[1]), .mem_rdata_i(mrdata[1]));

    mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(STARVE_MAX)) u_lat3 (
        .clk(clk), .rst(rst), .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_gnt_o(if_gnt[2]), .if_rvalid_o(if_rvalid[2]), .if_rdata_o(if_rdata[2]),
        .d_req_i(d_req), .d_addr_i(d_addr), .d_we_i(d_we), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt[2]), .d_rvalid_o(d_rvalid[2]), .d_rdata_o(d_rdata[2]),
        .mem_req_o(mreq[2]), .mem_addr_o(maddr[2]), .mem_we_o(mwe[2]),
        .mem_wdata_o(mwdata[2]), .mem_rdata_i(mrdata[2]));

    // Memory stand-in: a read of address A returns A + 0x100 after the instance latency.
    always @(posedge clk) begin
        hist[0] <= maddr[0];
        hist[1] <= hist[0];
        hist[2] <= hist[1];
    end
    assign mrdata[0] = hist[0] + 32'h100;
    assign mrdata[1] = hist[1] + 32'h100;
    assign mrdata[2] = hist[2] + 32'h100;

    typedef struct {
        int          inst;
        int          due;
        bit          is_if;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic       ifr;
        logic       dr;
        logic [3:0] we;
        logic       eif;
        logic       ed;
    } vec_t;

    resp_t pend [$];
    int    cyc = 0;
    int    denied = 0;
    int    passed = 0;
    int    total = 0;
    bit    m_if_gnt;
    bit    m_d_gnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // One clock cycle: drive inputs, compare all instances with the model, advance the model.
    task automatic step(input logic ifr, input logic [31:0] ifa, input logic fl,
                        input logic dr, input logic [31:0] da, input logic [3:0] dwe,
                        input logic [31:0] dwd, input logic r);
        bit          ev_if [3];
        bit          ev_d [3];
        logic [31:0] ed_if [3];
        logic [31:0] ed_d [3];
        resp_t       keep [$];
        @(negedge clk);
        if_req = ifr; if_addr = ifa; if_flush = fl;
        d_req = dr; d_addr = da; d_we = dwe; d_wdata = dwd; rst = r;
        #1;
        m_if_gnt = !r && ifr && (!dr || denied == STARVE_MAX);
        m_d_gnt  = !r && dr && !m_if_gnt;
        for (int k = 0; k < 3; k++) begin
            ev_if[k] = 1'b0; ev_d[k] = 1'b0; ed_if[k] = '0; ed_d[k] = '0;
        end
        foreach (pend[i]) begin
            if (pend[i].due == cyc && !r) begin
                if (pend[i].is_if && !fl) begin
                    ev_if[pend[i].inst] = 1'b1; ed_if[pend[i].inst] = pend[i].data;
                end else if (!pend[i].is_if) begin
                    ev_d[pend[i].inst] = 1'b1; ed_d[pend[i].inst] = pend[i].data;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk("if_gnt", 32'(if_gnt[k]), 32'(m_if_gnt));
            chk("d_gnt", 32'(d_gnt[k]), 32'(m_d_gnt));
            chk("mem_req", 32'(mreq[k]), 32'(m_if_gnt | m_d_gnt));
            if (m_if_gnt || m_d_gnt) begin
                chk("mem_addr", maddr[k], m_if_gnt ? ifa : da);
                chk("mem_we", 32'(mwe[k]), m_if_gnt ? 32'd0 : 32'(dwe));
            end
            if (m_d_gnt && dwe != 4'h0) chk("mem_wdata", mwdata[k], dwd);
            chk("if_rvalid", 32'(if_rvalid[k]), 32'(ev_if[k]));
            chk("d_rvalid", 32'(d_rvalid[k]), 32'(ev_d[k]));
            if (ev_if[k]) chk("if_rdata", if_rdata[k], ed_if[k]);
            if (ev_d[k]) chk("d_rdata", d_rdata[k], ed_d[k]);
        end
        foreach (pend[i]) begin
            if (!r && pend[i].due > cyc && !(fl && pend[i].is_if)) keep.push_back(pend[i]);
        end
        pend = keep;
        for (int k = 0; k < 3; k++) begin
            if (m_if_gnt && !fl)
                pend.push_back('{inst: k, due: cyc + k + 1, is_if: 1'b1, data: ifa + 32'h100});
            if (m_d_gnt && dwe == 4'h0)
                pend.push_back('{inst: k, due: cyc + k + 1, is_if: 1'b0, data: da + 32'h100});
        end
        if (r || !ifr || m_if_gnt) denied = 0;
        else if (denied < 15) denied++;
        cyc++;
    endtask

    task automatic idle(input logic fl, input logic r);
        step(1'b0, '0, fl, 1'b0, '0, 4'h0, '0, r);
    endtask

    initial begin
        vec_t tbl [12];
        bit          pi = 0, pd = 0;
        logic [31:0] pia = '0, pda = '0, pwd = '0;
        logic [3:0]  pwe = '0;
        logic        fl, r;

        tbl[0]  = '{ifr: 0, dr: 0, we: 4'h0, eif: 0, ed: 0};
        tbl[1]  = '{ifr: 1, dr: 0, we: 4'h0, eif: 1, ed: 0};
        tbl[2]  = '{ifr: 1, dr: 1, we: 4'h0, eif: 0, ed: 1};
        tbl[3]  = '{ifr: 1, dr: 1, we: 4'hF, eif: 0, ed: 1};
        tbl[4]  = '{ifr: 1, dr: 1, we: 4'h0, eif: 0, ed: 1};
        tbl[5]  = '{ifr: 1, dr: 1, we: 4'h0, eif: 1, ed: 0};
        tbl[6]  = '{ifr: 1, dr: 1, we: 4'h0, eif: 0, ed: 1};
        tbl[7]  = '{ifr: 0, dr: 1, we: 4'b0011, eif: 0, ed: 1};
        tbl[8]  = '{ifr: 1, dr: 1, we: 4'h0, eif: 0, ed: 1};
        tbl[9]  = '{ifr: 1, dr: 1, we: 4'h0, eif: 0, ed: 1};
        tbl[10] = '{ifr: 1, dr: 0, we: 4'h0, eif: 1, ed: 0};
        tbl[11] = '{ifr: 0, dr: 0, we: 4'h0, eif: 0, ed: 0};

        // Reset state: everything quiet while rst is high, even with requests present.
        step(1'b1, 32'h10, 1'b0, 1'b1, 32'h20, 4'h0, '0, 1'b1);
        chk("rst_if_gnt", 32'(if_gnt[0]), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt[0]), 32'd0);
        chk("rst_mem_req", 32'(mreq[0]), 32'd0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].ifr, 32'h1000 + 32'(i * 4), 1'b0, tbl[i].dr, 32'h2000 + 32'(i * 4),
                 tbl[i].we, 32'hA500_0000 + 32'(i), 1'b0);
            chk("tbl_if_gnt", 32'(if_gnt[0]), 32'(tbl[i].eif));
            chk("tbl_d_gnt", 32'(d_gnt[0]), 32'(tbl[i].ed));
            if (tbl[i].eif || tbl[i].ed)
                chk("tbl_mem_we", 32'(mwe[0]), tbl[i].ed ? 32'(tbl[i].we) : 32'd0);
        end

        // Back-to-back fetch, latency 1.
        idle(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(i < 4, 32'(i * 4), 1'b0, 1'b0, '0, 4'h0, '0, 1'b0);
            if (i > 0) begin
                chk("b2b_if_rvalid", 32'(if_rvalid[0]), 32'd1);
                chk("b2b_if_rdata", if_rdata[0], 32'h100 + 32'((i - 1) * 4));
            end
        end

        // Store produces no response.
        idle(1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 32'h40, 4'b0011, 32'hDEAD_BEEF, 1'b0);
        chk("wr_mem_we", 32'(mwe[0]), 32'h3);
        chk("wr_mem_wdata", mwdata[0], 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0, 1'b0);
            for (int k = 0; k < 3; k++) chk("wr_no_d_rvalid", 32'(d_rvalid[k]), 32'd0);
        end

        // Flush of in-flight fetches, latency 3, with a load granted in the flush cycle.
        idle(1'b0, 1'b1);
        step(1'b1, 32'h0, 1'b0, 1'b0, '0, 4'h0, '0, 1'b0);
        step(1'b1, 32'h4, 1'b0, 1'b0, '0, 4'h0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 32'h80, 4'h0, '0, 1'b0);
        chk("fl_load_gnt", 32'(d_gnt[2]), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            idle(1'b0, 1'b0);
            chk("fl_no_if_rvalid", 32'(if_rvalid[2]), 32'd0);
            chk("fl_d_rvalid", 32'(d_rvalid[2]), 32'(i == 3));
            if (i == 3) chk("fl_d_rdata", d_rdata[2], 32'h180);
        end

        // Flush coincident with the response, latency 1.
        idle(1'b0, 1'b1);
        step(1'b1, 32'h20, 1'b0, 1'b0, '0, 4'h0, '0, 1'b0);
        idle(1'b1, 1'b0);
        chk("flc_if_rvalid", 32'(if_rvalid[0]), 32'd0);
        idle(1'b0, 1'b0);
        chk("flc_if_rvalid_after", 32'(if_rvalid[0]), 32'd0);

        // Reset mid-operation, latency 2; starvation count restarts from zero.
        idle(1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 32'h44, 4'h0, '0, 1'b0);
        chk("rmo_load_gnt", 32'(d_gnt[1]), 32'd1);
        idle(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h300, 1'b0, 1'b1, 32'h400, 4'h0, '0, 1'b0);
            chk("rmo_d_gnt", 32'(d_gnt[1]), 32'(i < 3));
            chk("rmo_if_gnt", 32'(if_gnt[1]), 32'(i == 3));
            if (i < 2) chk("rmo_no_d_rvalid", 32'(d_rvalid[1]), 32'd0);
        end

        // Randomised traffic; requesters hold request and payload until granted.
        for (int n = 0; n < 600; n++) begin
            if (!pi) begin
                pi  = ($urandom_range(0, 99) < 60);
                pia = $urandom & 32'h0000_FFFC;
            end
            if (!pd) begin
                pd  = ($urandom_range(0, 99) < 55);
                pda = $urandom & 32'h0000_FFFC;
                pwe = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                pwd = $urandom;
            end
            fl = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 59) == 0);
            step(pi, pia, fl, pd, pda, pwe, pwd, r);
            if (m_if_gnt) pi = 0;
            if (m_d_gnt) pd = 0;
        end
        for (int i = 0; i < 4; i++) idle(1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
